// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_tx
//  Description : Serial bit-stream transmitter. Captures a parallel word and a
//                bit length, then shifts the word out MSB-first (bit len-1
//                first), one bit per clock. Optional loop mode repeats the
//                word back-to-back until stop is seen.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   synchronous active-high reset
//    start      in   transmit request, accepted only while ready=1
//    data       in   [WIDTH-1:0] pattern, data[len-1] sent first
//    len        in   [LEN_W-1:0] bits to send (0 ignored, >WIDTH clamped)
//    loop       in   captured with start; 1 = repeat word continuously
//    stop       in   ends loop mode after the current word completes
//    ready      out  high in IDLE
//    out        out  serial data bit
//    out_valid  out  high while out carries a pattern bit
//    bit_cnt    out  [LEN_W-1:0] index of the bit currently on out
//    done       out  one-cycle pulse after the final word ends
// ============================================================================
module serial_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic             loop,
  input  logic             stop,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic [LEN_W-1:0] bit_cnt,
  output logic             done
);

  localparam int             IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] C_WIDTH_LEN = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] C_ONE       = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic             loop_q,  loop_d;
  logic             stop_q,  stop_d;

  logic [LEN_W-1:0] len_clamped;

  // Oversized lengths send the full word rather than being rejected.
  assign len_clamped = (len > C_WIDTH_LEN) ? C_WIDTH_LEN : len;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    stop_d  = stop_q;

    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        cnt_d  = '0;
        if (start && (len != '0)) begin
          word_d  = data;
          len_d   = len_clamped;
          loop_d  = loop;
          cnt_d   = len_clamped - C_ONE;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (stop) begin
          stop_d = 1'b1;
        end
        if (cnt_q == '0) begin
          // A stop arriving on the last bit of a word counts as latched, so
          // the loop ends here instead of emitting one more full word.
          if (loop_q && !(stop_q || stop)) begin
            cnt_d = len_q - C_ONE;
          end else begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      S_DONE: begin
        stop_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign ready     = (state_q == S_IDLE);
  assign out_valid = (state_q == S_SEND);
  assign done      = (state_q == S_DONE);
  assign bit_cnt   = cnt_q;
  // cnt_q is always < WIDTH in SEND, so the low IDX_W bits form a safe index.
  assign out       = out_valid & word_q[cnt_q[IDX_W-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_pattern_tx
//  Description : Self-checking bench for serial_pattern_tx. Expected bits are
//                queued when a job is launched and popped as the DUT emits
//                valid bits; a small 1101 detector model watches the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  logic             loop;
  logic             stop;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic [LEN_W-1:0] bit_cnt;
  logic             done;

  serial_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .len      (len),
    .loop     (loop),
    .stop     (stop),
    .ready    (ready),
    .out      (out),
    .out_valid(out_valid),
    .bit_cnt  (bit_cnt),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entry: {expected out bit, expected bit_cnt}
  logic [LEN_W:0] exp_q[$];

  // 1101 detector model state: match positions (1-based bit index in the job)
  logic [31:0] det_mask;
  logic [3:0]  det_hist;
  int          det_pos;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge and score any bit the DUT is emitting.
  task automatic step();
    logic [LEN_W:0] e;
    @(negedge clk);
    if (out_valid === 1'b1) begin
      det_pos++;
      det_hist = {det_hist[2:0], out};
      if (det_hist == 4'b1101 && det_pos < 32) det_mask[det_pos] = 1'b1;
      if (exp_q.size() == 0) begin
        check_val("extra_bit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("out", {31'd0, out}, {31'd0, e[LEN_W]});
        check_val("bit_cnt", {27'd0, bit_cnt}, {27'd0, e[LEN_W-1:0]});
      end
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input int l);
    int n;
    n = (l > WIDTH) ? WIDTH : l;
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({d[i], LEN_W'(i)});
  endtask

  // Launch one job and follow it to done. stop_at = bit number after which
  // stop is raised (0 = never); meddle = disturb inputs during the first bit.
  task automatic run_job(input logic [WIDTH-1:0] d, input int l, input bit lp,
                         input int words, input int stop_at, input bit meddle);
    int nb;
    int n;
    bit seen;
    nb   = ((l > WIDTH) ? WIDTH : l) * words;
    n    = 0;
    seen = 1'b0;
    for (int w = 0; w < words; w++) push_word(d, l);
    det_mask = '0;
    det_hist = '0;
    det_pos  = 0;
    data  = d;
    len   = LEN_W'(l);
    loop  = lp;
    start = 1'b1;
    while (!seen && n < nb + 20) begin
      step();
      n++;
      start = 1'b0;
      stop  = 1'b0;
      if (meddle && n == 1) begin
        data  = '1;
        len   = LEN_W'(2);
        start = 1'b1;
      end
      if (stop_at == n) stop = 1'b1;
      if (done === 1'b1) begin
        seen = 1'b1;
        check_val("done_cycle", n, nb + 1);
        check_val("out_in_done", {31'd0, out}, 32'd0);
        // start during DONE must be ignored
        start = 1'b1;
        len   = LEN_W'(4);
      end
    end
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    step();
    start = 1'b0;
    check_val("ready_after", {31'd0, ready}, 32'd1);
    check_val("valid_after", {31'd0, out_valid}, 32'd0);
    check_val("done_one_cycle", {31'd0, done}, 32'd0);
    check_val("sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int dones;
    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    len   = '0;
    loop  = 1'b0;
    stop  = 1'b0;
    det_mask = '0;
    det_hist = '0;
    det_pos  = 0;

    // Reset state
    step();
    step();
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    check_val("rst_out", {31'd0, out}, 32'd0);
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_bit_cnt", {27'd0, bit_cnt}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();

    // 1: single word 1101, detector fires on bit 4 only
    run_job(16'h000D, 4, 1'b0, 1, 0, 1'b0);
    check_val("det_single", det_mask, 32'h0000_0010);

    // 2: loop mode, stop raised during bit 10 (2nd bit of word 3)
    run_job(16'h000D, 4, 1'b1, 3, 10, 1'b0);
    check_val("det_loop", det_mask, 32'h0000_1110);

    // 3: len=0 ignored
    data  = 16'hFFFF;
    len   = '0;
    start = 1'b1;
    bad   = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ready !== 1'b1 || out_valid !== 1'b0) bad++;
    end
    start = 1'b0;
    check_val("len0_ignored", bad, 32'd0);

    // 3: len=WIDTH and clamped len=20
    run_job(16'hA5C3, WIDTH, 1'b0, 1, 0, 1'b0);
    run_job(16'hA5C3, 20, 1'b0, 1, 0, 1'b0);

    // 4: input isolation while sending 1001
    run_job(16'h0009, 4, 1'b0, 1, 0, 1'b1);

    // 5: reset during bit 2 of a 7-bit job
    push_word(16'h0053, 7);
    data  = 16'h0053;
    len   = LEN_W'(7);
    loop  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check_val("abort_out", {31'd0, out}, 32'd0);
    check_val("abort_valid", {31'd0, out_valid}, 32'd0);
    check_val("abort_ready", {31'd0, ready}, 32'd1);
    check_val("abort_bit_cnt", {27'd0, bit_cnt}, 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    check_val("abort_no_done", dones, 32'd0);
    run_job(16'h0053, 7, 1'b0, 1, 0, 1'b0);

    // 6: overlapping matches 1101101 -> bits 4 and 7
    run_job(16'h006D, 7, 1'b0, 1, 0, 1'b0);
    check_val("det_overlap", det_mask, 32'h0000_0090);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
